// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    // Stage-register enable polarity: 0 loads, 1 holds.
    localparam logic EN_LOAD = 1'b0;
    localparam logic EN_HOLD = 1'b1;

    // Instruction word the stage registers capture when bubbled/flushed.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // A load in ID_EX writes a register the ID instruction is about to read.
    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       ex_mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        return ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs and stage-control outputs of the sequencer
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_enable;
    logic             IF_ID_enable;
    logic             ID_EX_enable;
    logic             EX_MEM_enable;
    logic             MEM_WB_enable;
    logic             ID_EX_bubble;
    logic             IF_ID_flush;
    logic             mem_timeout;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;

    // Datapath side: reports hazards, obeys the stage controls.
    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, mem_req, mem_ack,
        input  pc_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable,
               MEM_WB_enable, ID_EX_bubble, IF_ID_flush, mem_timeout,
               state, stall_cnt
    );

    // Sequencer side.
    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, mem_req, mem_ack,
        output pc_enable, IF_ID_enable, ID_EX_enable, EX_MEM_enable,
               MEM_WB_enable, ID_EX_bubble, IF_ID_flush, mem_timeout,
               state, stall_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q;

    // Count up on inc, stick at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    // One timer serves both the flush countdown and the memory-wait count,
    // so it is sized for whichever limit is larger.
    localparam int TMR_MAX = (MEM_TIMEOUT > FLUSH_CYCLES) ? MEM_TIMEOUT : FLUSH_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] FLUSH_LOAD = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST  = TMR_W'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;
    logic             load_use;

    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic bubble, flush;

    assign load_use = load_use_hazard(bus.ex_mem_read, bus.ex_rt, bus.id_rs,
                                      bus.id_rt, bus.id_uses_rt);

    // State, shared timer and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state: memory wait beats branch beats load-use; only RUN looks at hazards.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    state_d = ST_MEM_WAIT;
                    timer_d = '0;
                end else if (bus.ex_branch_taken) begin
                    state_d = ST_FLUSH;
                    timer_d = FLUSH_LOAD;
                end else if (load_use) begin
                    state_d = ST_LOAD_STALL;
                end
            end
            ST_LOAD_STALL: begin
                state_d = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else if (timer_q == WAIT_LAST) begin
                    state_d   = ST_RUN;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_FLUSH: begin
                if (timer_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                timer_d = '0;
            end
        endcase
    end

    // Moore decode of the stage controls from the registered state.
    always_comb begin
        pc_en     = EN_LOAD;
        if_id_en  = EN_LOAD;
        id_ex_en  = EN_LOAD;
        ex_mem_en = EN_LOAD;
        mem_wb_en = EN_LOAD;
        bubble    = 1'b0;
        flush     = 1'b0;
        case (state_q)
            ST_LOAD_STALL: begin
                pc_en    = EN_HOLD;
                if_id_en = EN_HOLD;
                bubble   = 1'b1;
            end
            ST_MEM_WAIT: begin
                pc_en     = EN_HOLD;
                if_id_en  = EN_HOLD;
                id_ex_en  = EN_HOLD;
                ex_mem_en = EN_HOLD;
                mem_wb_en = EN_HOLD;
            end
            ST_FLUSH: begin
                flush  = 1'b1;
                bubble = 1'b1;
            end
            default: begin
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_i (!rst_n),
        .inc_i (state_q != ST_RUN),
        .cnt_o (bus.stall_cnt)
    );

    assign bus.pc_enable     = pc_en;
    assign bus.IF_ID_enable  = if_id_en;
    assign bus.ID_EX_enable  = id_ex_en;
    assign bus.EX_MEM_enable = ex_mem_en;
    assign bus.MEM_WB_enable = mem_wb_en;
    assign bus.ID_EX_bubble  = bubble;
    assign bus.IF_ID_flush   = flush;
    assign bus.mem_timeout   = timeout_q;
    assign bus.state         = state_q;
endmodule
